// File: rtl/stack_calc_ctrl.sv
// Stack-based calculator controller. A RAM-backed stack grows downward
// from the top address; buttons trigger push/pop/arith/display commands,
// with the operation bank selected by mode.
module stack_calc_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        btns,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] operand,
   output logic              we,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              empty,
   output logic              full,
   output logic              err,
   output logic              carry,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, EXEC} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DUP} op_t;

   localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_TWO  = (ADDR_W+1)'(2);
   localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

   state_t              state;
   op_t                 op;
   logic [ADDR_W-1:0]   sp;
   logic [ADDR_W-1:0]   dar;
   logic [ADDR_W:0]     count;
   logic [3:0]          btns_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   wr_data;
   logic                idle_q;

   logic [3:0]          rise;
   logic                cmd_hit;
   logic [1:0]          cmd_idx;
   logic [ADDR_W-1:0]   top_addr;
   logic [ADDR_W-1:0]   sec_addr;
   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   result;
   logic                res_carry;

   assign rise      = btns & ~btns_q;
   assign top_addr  = sp + ADDR_ONE;
   assign sec_addr  = sp + ADDR_TWO;
   assign empty     = (count == '0);
   assign full      = (count == CNT_FULL);
   assign busy      = (state != IDLE);
   assign disp_addr = dar;

   // B is the second entry, arriving on data_in during EXEC; A was captured in RD_B.
   assign sum  = {1'b0, data_in} + {1'b0, a_q};
   assign diff = {1'b0, data_in} - {1'b0, a_q};
   assign prod = {{DATA_W{1'b0}}, data_in} * {{DATA_W{1'b0}}, a_q};

   // Pick the highest-priority rising edge this cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      cmd_hit = 1'b1;
      cmd_idx = 2'd0;
      if (rise[3])      cmd_idx = 2'd3;
      else if (rise[2]) cmd_idx = 2'd2;
      else if (rise[1]) cmd_idx = 2'd1;
      else if (!rise[0]) cmd_hit = 1'b0;
   end

   // Arithmetic result and carry/borrow/overflow flag for the latched op.
   always_comb begin
      result    = sum[DATA_W-1:0];
      res_carry = sum[DATA_W];
      case (op)
         OP_SUB: begin
            result    = diff[DATA_W-1:0];
            res_carry = diff[DATA_W];
         end
         OP_MUL: begin
            result    = prod[DATA_W-1:0];
            res_carry = |prod[2*DATA_W-1:DATA_W];
         end
         default: ;
      endcase
   end

   // RAM port decode from the current state; reset forces IDLE so we drops at once.
   always_comb begin
      we       = 1'b0;
      address  = dar;
      data_out = wr_data;
      case (state)
         WR: begin
            we      = 1'b1;
            address = sp;
         end
         RD_A: address = top_addr;
         RD_B: address = sec_addr;
         EXEC: begin
            we       = 1'b1;
            address  = sec_addr;
            data_out = result;
         end
         default: ;
      endcase
   end

   // Button history and display capture of the word read at DAR while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btns_q    <= '0;
         idle_q    <= 1'b0;
         disp_data <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         btns_q <= btns;
         idle_q <= (state == IDLE);
         if (idle_q) disp_data <= data_in;
      end
   end

   // Command FSM: stack pointer, count, DAR, flags and operand capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op      <= OP_ADD;
         sp      <= ADDR_TOP;
         dar     <= ADDR_TOP;
         count   <= '0;
         a_q     <= '0;
         wr_data <= '0;
         err     <= 1'b0;
         carry   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_hit) begin
               if (cmd_idx == 2'd3) begin
                  sp    <= ADDR_TOP;
                  dar   <= ADDR_TOP;
                  count <= '0;
                  err   <= 1'b0;
                  carry <= 1'b0;
               end else begin
                  case (mode)
                     2'b00: case (cmd_idx)
                        2'd0: if (full) err <= 1'b1;
                              else begin
                                 wr_data <= operand;
                                 state   <= WR;
                              end
                        2'd1: if (empty) err <= 1'b1;
                              else begin
                                 sp    <= top_addr;
                                 count <= count - CNT_ONE;
                                 dar   <= sec_addr;
                              end
                        default: if (full) err <= 1'b1;
                              else begin
                                 op    <= OP_DUP;
                                 state <= RD_A;
                              end
                     endcase
                     2'b01: if (count < CNT_TWO) err <= 1'b1;
                            else begin
                               op    <= (cmd_idx == 2'd0) ? OP_ADD :
                                        (cmd_idx == 2'd1) ? OP_SUB : OP_MUL;
                               state <= RD_A;
                            end
                     2'b10: case (cmd_idx)
                        2'd0:    if (empty) err <= 1'b1;
                                 else dar <= top_addr;
                        2'd1:    dar <= dar + ADDR_ONE;
                        default: dar <= dar - ADDR_ONE;
                     endcase
                     default: ;
                  endcase
               end
            end
            RD_A: state <= RD_B;
            RD_B: begin
               a_q     <= data_in;
               wr_data <= data_in;
               state   <= (op == OP_DUP) ? WR : EXEC;
            end
            WR: begin
               sp    <= sp - ADDR_ONE;
               count <= count + CNT_ONE;
               dar   <= sp;
               state <= IDLE;
            end
            EXEC: begin
               sp    <= top_addr;
               count <= count - CNT_ONE;
               dar   <= sec_addr;
               carry <= res_carry;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/stack_calc_ctrl.md
STACK_CALC_CTRL -- requirements
Module: stack_calc_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, stack word width in bits.
REQ-002 Parameter ADDR_W, default 7, RAM address width; stack capacity DEPTH = 2^ADDR_W words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 btns  in  4  level button inputs, already debounced and synchronous to clk.
REQ-006 mode  in  2  operation bank select, sampled when a command is accepted.
REQ-007 operand  in  DATA_W  value pushed by PUSH.
REQ-008 we  out  1  RAM write enable.
REQ-009 address  out  ADDR_W  RAM address.
REQ-010 data_out  out  DATA_W  RAM write data.
REQ-011 data_in  in  DATA_W  RAM read data; synchronous read, valid one cycle after address.
REQ-012 disp_addr  out  ADDR_W  display address register (DAR).
REQ-013 disp_data  out  DATA_W  RAM contents at DAR.
REQ-014 empty, full, err, carry, busy  out  1 each  status flags.

Function
REQ-015 Command trigger is a rising edge of a btns bit, detected against a registered copy of btns.
REQ-016 Commands are accepted only in IDLE; edges arriving while busy=1 are dropped and are not queued.
REQ-017 Simultaneous edges are resolved by priority btns[3] > [2] > [1] > [0]; only the highest-priority edge executes.
REQ-018 btns[3] is CLEAR in every mode: SP=DEPTH-1, count=0, DAR=DEPTH-1, err=0, carry=0; RAM contents are left untouched; completes in 1 cycle.
REQ-019 Mode 00 commands: btns[0] PUSH; btns[1] POP; btns[2] DUP (pushes a copy of the top entry).
REQ-020 Mode 01 commands: btns[0] ADD; btns[1] SUB; btns[2] MUL (low DATA_W bits of the product).
REQ-021 Mode 10 commands: btns[0] TOP (DAR=SP+1); btns[1] DAR+1; btns[2] DAR-1; DAR changes wrap modulo DEPTH.
REQ-022 Mode 11 is reserved; every edge in mode 11 except btns[3] is a no-op.
REQ-023 Stack layout: the stack grows downward from address DEPTH-1.
REQ-024 SP is the next free address; count, ADDR_W+1 bits, holds the number of entries.
REQ-025 empty = (count==0); full = (count==DEPTH).
REQ-026 The top entry is at SP+1 and the second entry at SP+2, both modulo DEPTH.
REQ-027 FSM states are IDLE, WR, RD_A, RD_B, EXEC.
REQ-028 busy=1 in every state except IDLE.
REQ-029 In IDLE: address=DAR, we=0; disp_data loads data_in on each cycle whose previous cycle was IDLE.
REQ-030 PUSH, IDLE->WR: in WR, we=1, address=SP, data_out=operand; then SP-=1, count+=1, DAR=old SP; return to IDLE.
REQ-031 POP, handled in IDLE: SP+=1, count-=1, DAR=SP+2 (the new top); completes in 1 cycle with no RAM access.
REQ-032 DUP path: IDLE->RD_A->RD_B->WR; RD_A address=SP+1; the data captured in RD_B is written at SP by WR.
REQ-033 Binary ops path: IDLE->RD_A (address SP+1)->RD_B (address SP+2, capture A=data_in)->EXEC (capture B=data_in).
REQ-034 In EXEC: we=1, address=SP+2, data_out=result; then SP+=1, count-=1, DAR=SP+2; return to IDLE.
REQ-035 Binary op results: ADD = B+A, carry = carry-out; SUB = B-A, carry = borrow (B<A); MUL = (B*A)[DATA_W-1:0], carry = 1 if the high half is nonzero.
REQ-036 Arithmetic wraps modulo 2^DATA_W; carry updates only on ADD/SUB/MUL and holds otherwise.
REQ-037 Error rules: PUSH or DUP when full, POP when empty, TOP when empty, and a binary op when count<2 each set err=1.
REQ-038 An erroring command changes no other state, issues no RAM write, and completes in 1 cycle.
REQ-039 err is sticky until CLEAR or reset.
REQ-040 Latency from accepted edge to return to IDLE: PUSH 2 cycles, POP/CLEAR/TOP/DAR 1, DUP 4, ADD/SUB/MUL 4.
REQ-041 we is asserted only in WR and EXEC and for exactly one cycle per command.

Reset
REQ-042 While rst_n=0: state=IDLE, SP=DEPTH-1, count=0, DAR=DEPTH-1, disp_data=0, we=0, address=DEPTH-1, data_out=0, err=0, carry=0, busy=0, empty=1, full=0, registered btns=0.
REQ-043 Reset asserted mid-command aborts the command; no write occurs after reset asserts.
REQ-044 After rst_n rises, the first command is accepted no earlier than the next edge detected.

Verification
REQ-045 Bench scenario, push/add (DATA_W=8): push 0x05, push 0xFE, ADD -> RAM[0x7F]=0x03, carry=1, count=1, DAR=0x7F, disp_data=0x03.
REQ-046 Bench scenario, SUB/MUL: push 0x03, push 0x07, SUB -> top=0xFC, carry=1; push 0x02, MUL -> top=0xF8, carry=1.
REQ-047 Bench scenario, underflow: POP on empty -> err=1, SP=0x7F, no we; POP again -> err stays 1; CLEAR -> err=0.
REQ-048 Bench scenario, fill (ADDR_W=3): 8 pushes -> full=1, SP=7 (wrapped); ninth push -> err=1, no we.
REQ-049 Bench scenario, contention: btns[0] and btns[1] rise together in mode 00 -> only POP-priority btns[1] executes; an edge during an ADD (busy=1) is dropped.
REQ-050 Bench scenario, reset in EXEC: rst_n low in EXEC -> we=0 immediately, count=0, disp_addr=0x7F.
